// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, FSM state encodings, datapath select codes and the control word shared by the multicycle controller.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC, S_R_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
    endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// mc_output_decode: combinational Moore decode of FSM state into datapath control word.
// Ports: state (current FSM state), mem_ready (memory handshake, used in FETCH),
//        opcode (IR[31:26], used in DECODE for the illegal flag), ctrl (control word out).
module mc_output_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_BR;
                ctrl.illegal_op = !op_legal(opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing a shared-memory multicycle MIPS datapath, with retired-instruction counter.
// Ports: CLK/RESET (async active-high), opcode (IR[31:26]), Mem_ready (memory handshake);
//        PC/IR/regfile/ALU/memory enables and selects; Illegal_op (DECODE pulse); Instr_count (retired count).
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [5:0]       opcode,
    input  logic             Mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             Illegal_op,
    output logic [CNT_W-1:0] Instr_count
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctrl_t            ctrl, ctrl_o;

    mc_output_decode u_dec (
        .state    (state_q),
        .mem_ready(Mem_ready),
        .opcode   (opcode),
        .ctrl     (ctrl)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    state_d = Mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_R:         state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = Mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_d = Mem_ready ? S_FETCH : S_MEM_WR;
                retire  = Mem_ready;
            end
            S_EXEC:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        count_d = count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Outputs are silenced for as long as RESET is held, even though the state already reads FETCH.
    assign ctrl_o      = RESET ? ctrl_t'('0) : ctrl;
    assign PCWrite     = ctrl_o.pc_write;
    assign PCWriteCond = ctrl_o.pc_write_cond;
    assign IorD        = ctrl_o.i_or_d;
    assign MemRead     = ctrl_o.mem_read;
    assign MemWrite    = ctrl_o.mem_write;
    assign IRWrite     = ctrl_o.ir_write;
    assign MemtoReg    = ctrl_o.mem_to_reg;
    assign RegDst      = ctrl_o.reg_dst;
    assign RegWrite    = ctrl_o.reg_write;
    assign ALUSrcA     = ctrl_o.alu_src_a;
    assign ALUSrcB     = ctrl_o.alu_src_b;
    assign ALUOp       = ctrl_o.alu_op;
    assign PCSource    = ctrl_o.pc_source;
    assign Illegal_op  = ctrl_o.illegal_op;
    assign Instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven scoreboard bench for the multicycle MIPS controller (CNT_W=4 to exercise wrap).
module tb_multicycle_control;
    localparam int CW = 4;
    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111;
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,Illegal_op}
    localparam logic [16:0] Z       = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] F_RDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] F_WAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] MA      = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] MR      = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] MWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] MWB     = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] EX      = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] AWB     = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] BR      = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] JMP     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;

    logic CLK = 1'b0, RESET = 1'b1, Mem_ready = 1'b0;
    logic [5:0] opcode = '0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [CW-1:0] Instr_count;
    logic [16:0] act;

    multicycle_control #(.CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .Mem_ready(Mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal_op(Illegal_op), .Instr_count(Instr_count)
    );

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal_op};

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [16:0] exp;
        logic        ret;
        string       name;
    } vec_t;

    typedef struct {
        logic [16:0]   ctl;
        logic [CW-1:0] cnt;
        string         name;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int n_vec = 0, n_bad = 0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic add(input string name, input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [16:0] exp, input logic ret);
        vec_t v;
        v.name = name; v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp; v.ret = ret;
        vt.push_back(v);
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET = v.rst;
        opcode = v.op;
        Mem_ready = v.rdy;
        if (v.rst) exp_cnt = '0;
        e.ctl = v.exp;
        e.cnt = exp_cnt;
        e.name = v.name;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        n_vec++;
        if (act !== e.ctl || Instr_count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                     e.name, act, Instr_count, e.ctl, e.cnt);
        end
        if (v.ret) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic r_type(input string name);
        vec_t v;
        add(name, 0, R, 1, F_RDY, 0);
        add(name, 0, R, 1, DEC, 0);
        add(name, 0, R, 1, EX, 0);
        add(name, 0, R, 1, RWB, 1);
    endtask

    initial begin
        add("reset0", 1, R, 0, Z, 0);
        add("reset1", 1, R, 1, Z, 0);
        add("lw_fetch", 0, LW, 1, F_RDY, 0);
        add("lw_decode", 0, LW, 1, DEC, 0);
        add("lw_addr", 0, LW, 1, MA, 0);
        add("lw_read", 0, LW, 1, MR, 0);
        add("lw_wb", 0, LW, 1, MWB, 1);
        for (int i = 0; i < 4; i++) add("stall_fetch", 0, R, 0, F_WAIT, 0);
        add("stall_go", 0, R, 1, F_RDY, 0);
        add("r_decode", 0, R, 1, DEC, 0);
        add("r_exec_rdy_ignored", 0, R, 0, EX, 0);
        add("r_wb", 0, R, 0, RWB, 1);
        add("beq_fetch", 0, BEQ, 1, F_RDY, 0);
        add("beq_decode", 0, BEQ, 1, DEC, 0);
        add("beq_branch", 0, BEQ, 1, BR, 1);
        add("j_fetch", 0, J, 1, F_RDY, 0);
        add("j_decode", 0, J, 1, DEC, 0);
        add("j_jump", 0, J, 1, JMP, 1);
        add("ill_fetch", 0, BAD, 1, F_RDY, 0);
        add("ill_decode", 0, BAD, 1, DEC_ILL, 0);
        add("ill_back_fetch", 0, BAD, 0, F_WAIT, 0);
        add("lw2_fetch", 0, LW, 1, F_RDY, 0);
        add("lw2_decode", 0, LW, 1, DEC, 0);
        add("lw2_addr", 0, LW, 0, MA, 0);
        add("lw2_read_wait", 0, LW, 0, MR, 0);
        add("lw2_read_go", 0, LW, 1, MR, 0);
        add("lw2_wb", 0, LW, 0, MWB, 1);
        add("sw_fetch", 0, SW, 1, F_RDY, 0);
        add("sw_decode", 0, SW, 1, DEC, 0);
        add("sw_addr", 0, SW, 1, MA, 0);
        add("sw_write_wait", 0, SW, 0, MWR, 0);
        add("sw_write_go", 0, SW, 1, MWR, 1);
        add("addi_fetch", 0, ADDI, 1, F_RDY, 0);
        add("addi_decode", 0, ADDI, 1, DEC, 0);
        add("addi_exec", 0, ADDI, 1, MA, 0);
        add("addi_wb", 0, ADDI, 1, AWB, 1);
        add("sw2_fetch", 0, SW, 1, F_RDY, 0);
        add("sw2_decode", 0, SW, 1, DEC, 0);
        add("sw2_addr", 0, SW, 0, MA, 0);
        add("sw2_write_wait", 0, SW, 0, MWR, 0);
        for (int i = 0; i < 3; i++) add("reset_mid_sw", 1, SW, 0, Z, 0);
        add("post_reset_fetch", 0, SW, 0, F_WAIT, 0);
        add("post_reset_fetch_go", 0, SW, 1, F_RDY, 0);
        add("wrap_reset", 1, R, 0, Z, 0);
        for (int i = 0; i < 16; i++) r_type("wrap_r");
        add("wrap_zero", 0, R, 0, F_WAIT, 0);
        for (int i = 0; i < vt.size(); i++) step(vt[i]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
